// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI command/register controller:
// FSM states, command byte layout, ID address and status byte layout.
package spi_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WRITE,
      S_READ,
      S_DISCARD
   } state_t;

   localparam int CMD_RW_BIT  = 7;
   localparam int CMD_AI_BIT  = 6;
   localparam int CMD_RSV_MSB = 5;
   localparam int CMD_RSV_LSB = 4;

   localparam logic [3:0] ID_ADDR = 4'hF;

   // Status byte returned during the command slot: only bit 0 (err) is used.
   localparam int STATUS_ERR_BIT = 0;

   function automatic logic [7:0] status_byte(input logic err_flag);
      logic [7:0] s;
      s = 8'h00;
      s[STATUS_ERR_BIT] = err_flag;
      return s;
   endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Byte register file with one synchronous write port, one combinational
// read port (including the read-only ID byte) and a flat view of all registers.
module spi_reg_file
   import spi_ctrl_pkg::*;
#(
   parameter int         NUM_REGS = 4,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [3:0]              wr_addr,
   input  logic [7:0]              wr_data,
   input  logic [3:0]              rd_addr,
   output logic [7:0]              rd_data,
   output logic [NUM_REGS*8-1:0]   regs_flat
);

   logic [NUM_REGS*8-1:0] regs_reg;
   logic [NUM_REGS-1:0]   wr_sel;

   generate
      for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (wr_addr == 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         regs_reg <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_sel[i]) begin
               regs_reg[i*8 +: 8] <= wr_data;
            end
         end
      end
   end

   // Unmapped addresses read as zero; the controller never selects them.
   always_comb begin
      rd_data = 8'h00;
      if (rd_addr == ID_ADDR) begin
         rd_data = ID_VALUE;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == 4'(i)) begin
               rd_data = regs_reg[i*8 +: 8];
            end
         end
      end
   end

   assign regs_flat = regs_reg;

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI frame parser: command byte then data bytes, performing register
// writes/reads with optional auto-increment; drives display value and MISO byte.
module spi_reg_ctrl
   import spi_ctrl_pkg::*;
#(
   parameter int         NUM_REGS = 4,
   parameter logic [7:0] ID_VALUE = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cs_n,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   output logic [7:0]              tx_byte,
   output logic [NUM_REGS*8-1:0]   regs_flat,
   output logic [15:0]             disp_value,
   output logic                    err,
   output logic                    frame_done
);

   localparam logic [3:0] LAST_ADDR = 4'(NUM_REGS - 1);

   state_t     state_reg, state_next;
   logic [3:0] addr_reg, addr_next;
   logic       ai_reg, ai_next;
   logic       err_reg, err_next;
   logic [7:0] tx_reg, tx_next;
   logic       frame_done_reg, frame_done_next;
   logic       cs_prev_reg;

   logic       cs_fall;
   logic       cmd_ok;
   logic [3:0] addr_adv;
   logic       wr_en;
   logic [3:0] rd_addr;
   logic [7:0] rd_data;

   spi_reg_file #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) u_reg_file (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_addr   (addr_reg),
      .wr_data   (rx_byte),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .regs_flat (regs_flat)
   );

   // cs_prev resets low so a frame already active at reset release is not
   // mistaken for a new one; cs_n must be seen high before a falling edge counts.
   assign cs_fall = cs_prev_reg && !cs_n;

   assign cmd_ok = (rx_byte[CMD_RSV_MSB:CMD_RSV_LSB] == 2'b00) &&
                   ((rx_byte[3:0] == ID_ADDR) || (rx_byte[3:0] <= LAST_ADDR));

   always_comb begin
      addr_adv = addr_reg;
      if (ai_reg && (addr_reg != ID_ADDR)) begin
         addr_adv = (addr_reg == LAST_ADDR) ? 4'd0 : addr_reg + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg      <= S_IDLE;
         addr_reg       <= 4'd0;
         ai_reg         <= 1'b0;
         err_reg        <= 1'b0;
         tx_reg         <= 8'h00;
         frame_done_reg <= 1'b0;
         cs_prev_reg    <= 1'b0;
      end else begin
         state_reg      <= state_next;
         addr_reg       <= addr_next;
         ai_reg         <= ai_next;
         err_reg        <= err_next;
         tx_reg         <= tx_next;
         frame_done_reg <= frame_done_next;
         cs_prev_reg    <= cs_n;
      end
   end

   always_comb begin
      state_next      = state_reg;
      addr_next       = addr_reg;
      ai_next         = ai_reg;
      err_next        = err_reg;
      tx_next         = tx_reg;
      frame_done_next = 1'b0;
      wr_en           = 1'b0;
      rd_addr         = addr_reg;

      case (state_reg)
         S_IDLE: begin
            if (cs_fall) begin
               state_next = S_CMD;
               tx_next    = status_byte(err_reg);
            end
         end
         S_CMD: begin
            if (rx_valid) begin
               if (!cmd_ok) begin
                  state_next = S_DISCARD;
                  err_next   = 1'b1;
                  tx_next    = 8'h00;
               end else begin
                  addr_next = rx_byte[3:0];
                  ai_next   = rx_byte[CMD_AI_BIT];
                  if (rx_byte[CMD_RW_BIT]) begin
                     state_next = S_READ;
                     rd_addr    = rx_byte[3:0];
                     tx_next    = rd_data;
                  end else begin
                     state_next = S_WRITE;
                  end
               end
            end
         end
         S_WRITE: begin
            if (rx_valid) begin
               if (addr_reg == ID_ADDR) begin
                  err_next = 1'b0;
               end else begin
                  wr_en = 1'b1;
               end
               addr_next = addr_adv;
            end
         end
         S_READ: begin
            if (rx_valid) begin
               addr_next = addr_adv;
               rd_addr   = addr_adv;
               tx_next   = rd_data;
            end
         end
         S_DISCARD: begin
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase

      // Frame end overrides the state only; a byte arriving in the same cycle
      // has already been applied above.
      if ((state_reg != S_IDLE) && cs_n) begin
         state_next      = S_IDLE;
         frame_done_next = 1'b1;
      end
   end

   assign tx_byte    = tx_reg;
   assign err        = err_reg;
   assign frame_done = frame_done_reg;
   assign disp_value = regs_flat[15:0];

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: directed frame table, hand-written
// corner sequences and random frames checked against a frame-level model.
module tb_spi_reg_ctrl;

   localparam int         NUM_REGS = 4;
   localparam logic [7:0] ID_VALUE = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cs_n;
   logic        rx_valid;
   logic [7:0]  rx_byte;
   logic [7:0]  tx_byte;
   logic [31:0] regs_flat;
   logic [15:0] disp_value;
   logic        err;
   logic        frame_done;

   always #5 clk = ~clk;

   spi_reg_ctrl #(
      .NUM_REGS (NUM_REGS),
      .ID_VALUE (ID_VALUE)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cs_n       (cs_n),
      .rx_valid   (rx_valid),
      .rx_byte    (rx_byte),
      .tx_byte    (tx_byte),
      .regs_flat  (regs_flat),
      .disp_value (disp_value),
      .err        (err),
      .frame_done (frame_done)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Frame-level reference state
   logic [7:0]  m_regs [16];
   logic        m_err;

   logic [7:0]  fbuf [8];
   logic [7:0]  etx  [9];
   logic        echk [9];
   logic [31:0] exp_flat;
   logic        exp_err;

   typedef struct packed {
      logic [3:0]  len;    // total bytes including the command
      logic [39:0] bytes;  // first byte in the top byte
      logic [5:0]  txm;    // slot k checked when txm[5-k] set
      logic [47:0] tx;     // slot k expected at tx[47-8k -: 8]
      logic [31:0] regs;   // {reg3, reg2, reg1, reg0} after the frame
      logic        err;
   } vec_t;

   vec_t vecs [13];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_total++;
      if (act === expv) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
   endtask

   task automatic send(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   function automatic logic [7:0] mval(input logic [3:0] a);
      if (a == 4'hF) return ID_VALUE;
      return m_regs[a];
   endfunction

   function automatic logic [3:0] madv(input logic [3:0] a, input logic ai);
      if (!ai || a == 4'hF) return a;
      return 4'((32'(a) + 1) % NUM_REGS);
   endfunction

   function automatic logic [31:0] mflat();
      logic [31:0] f;
      for (int i = 0; i < NUM_REGS; i++) f[i*8 +: 8] = m_regs[i];
      return f;
   endfunction

   // Apply one frame (fbuf[0..len-1]) to the model; fill expected tx slots.
   task automatic model_frame(input int len);
      logic [7:0] c;
      logic [3:0] a;
      logic       ai;
      for (int k = 0; k < 9; k++) begin
         echk[k] = 1'b0;
         etx[k]  = 8'h00;
      end
      etx[0]  = {7'b0, m_err};
      echk[0] = 1'b1;
      c  = fbuf[0];
      a  = c[3:0];
      ai = c[6];
      if (c[5:4] != 2'b00 || !(a == 4'hF || 32'(a) < NUM_REGS)) begin
         m_err = 1'b1;
         for (int k = 1; k <= len; k++) echk[k] = 1'b1;
      end else if (c[7]) begin
         etx[1]  = mval(a);
         echk[1] = 1'b1;
         for (int k = 1; k < len; k++) begin
            a           = madv(a, ai);
            etx[k + 1]  = mval(a);
            echk[k + 1] = 1'b1;
         end
      end else begin
         for (int k = 1; k < len; k++) begin
            if (a == 4'hF) m_err = 1'b0;
            else m_regs[a] = fbuf[k];
            a = madv(a, ai);
         end
      end
      exp_flat = mflat();
      exp_err  = m_err;
   endtask

   task automatic run_frame(input int len, input logic coincide);
      logic last;
      cs_n = 1'b0;
      tick();
      if (echk[0]) chk("status_slot", 32'(tx_byte), 32'(etx[0]));
      for (int i = 0; i < len; i++) begin
         if ($urandom_range(0, 1) == 1) tick();
         last     = (i == len - 1);
         rx_byte  = fbuf[i];
         rx_valid = 1'b1;
         if (coincide && last) cs_n = 1'b1;
         tick();
         rx_valid = 1'b0;
         if (echk[i + 1] && !(coincide && last))
            chk($sformatf("tx_slot%0d", i + 1), 32'(tx_byte), 32'(etx[i + 1]));
      end
      chk("regs_after_last", regs_flat, exp_flat);
      chk("disp_value", 32'(disp_value), 32'(exp_flat[15:0]));
      if (!coincide) begin
         tick();
         cs_n = 1'b1;
         tick();
      end
      chk("frame_done_pulse", 32'(frame_done), 32'd1);
      chk("err_after_frame", 32'(err), 32'(exp_err));
      tick();
      chk("frame_done_clear", 32'(frame_done), 32'd0);
      $display("frame cmd=%02h len=%0d coincide=%0d tx0=%02h regs=%08h err=%0b",
               fbuf[0], len, coincide, etx[0], regs_flat, err);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] c;
      logic [3:0] a;
      int         len;
      logic       co;

      vecs[0]  = '{len:4'd3, bytes:40'h40_34_12_00_00, txm:6'b100000, tx:48'h00_00_00_00_00_00, regs:32'h0000_1234, err:1'b0};
      vecs[1]  = '{len:4'd5, bytes:40'h40_11_22_33_44, txm:6'b100000, tx:48'h00_00_00_00_00_00, regs:32'h4433_2211, err:1'b0};
      vecs[2]  = '{len:4'd4, bytes:40'hC2_FF_FF_FF_00, txm:6'b111110, tx:48'h00_33_44_11_22_00, regs:32'h4433_2211, err:1'b0};
      vecs[3]  = '{len:4'd2, bytes:40'h35_FF_00_00_00, txm:6'b111000, tx:48'h00_00_00_00_00_00, regs:32'h4433_2211, err:1'b1};
      vecs[4]  = '{len:4'd3, bytes:40'h8F_00_00_00_00, txm:6'b111100, tx:48'h01_A5_A5_A5_00_00, regs:32'h4433_2211, err:1'b1};
      vecs[5]  = '{len:4'd3, bytes:40'hCF_00_00_00_00, txm:6'b111100, tx:48'h01_A5_A5_A5_00_00, regs:32'h4433_2211, err:1'b1};
      vecs[6]  = '{len:4'd2, bytes:40'h0F_00_00_00_00, txm:6'b100000, tx:48'h01_00_00_00_00_00, regs:32'h4433_2211, err:1'b0};
      vecs[7]  = '{len:4'd2, bytes:40'h84_12_00_00_00, txm:6'b111000, tx:48'h00_00_00_00_00_00, regs:32'h4433_2211, err:1'b1};
      vecs[8]  = '{len:4'd3, bytes:40'h4F_55_66_00_00, txm:6'b100000, tx:48'h01_00_00_00_00_00, regs:32'h4433_2211, err:1'b0};
      vecs[9]  = '{len:4'd3, bytes:40'h03_AA_BB_00_00, txm:6'b100000, tx:48'h00_00_00_00_00_00, regs:32'hBB33_2211, err:1'b0};
      vecs[10] = '{len:4'd3, bytes:40'h83_00_00_00_00, txm:6'b111100, tx:48'h00_BB_BB_BB_00_00, regs:32'hBB33_2211, err:1'b0};
      vecs[11] = '{len:4'd3, bytes:40'hC3_00_00_00_00, txm:6'b111100, tx:48'h00_BB_11_22_00_00, regs:32'hBB33_2211, err:1'b0};
      vecs[12] = '{len:4'd1, bytes:40'h8F_00_00_00_00, txm:6'b110000, tx:48'h00_A5_00_00_00_00, regs:32'hBB33_2211, err:1'b0};

      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_err    = 1'b0;
      rst_n    = 1'b0;
      cs_n     = 1'b0;
      rx_valid = 1'b0;
      rx_byte  = 8'h00;

      // Reset with cs_n already low: the ongoing frame must be ignored.
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      chk("rst_regs", regs_flat, 32'h0);
      chk("rst_tx", 32'(tx_byte), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_frame_done", 32'(frame_done), 32'h0);
      send(8'h00);
      send(8'h40);
      send(8'h55);
      chk("no_edge_regs", regs_flat, 32'h0);
      chk("no_edge_tx", 32'(tx_byte), 32'h0);
      chk("no_edge_frame_done", 32'(frame_done), 32'h0);
      cs_n = 1'b1;
      tick();
      tick();
      $display("reset-in-frame sequence regs=%08h", regs_flat);

      // Directed frame table
      for (int v = 0; v < 13; v++) begin
         for (int k = 0; k < int'(vecs[v].len); k++) fbuf[k] = vecs[v].bytes[39 - 8*k -: 8];
         model_frame(int'(vecs[v].len));
         for (int k = 0; k < 6; k++) begin
            echk[k] = vecs[v].txm[5 - k];
            etx[k]  = vecs[v].tx[47 - 8*k -: 8];
         end
         exp_flat = vecs[v].regs;
         exp_err  = vecs[v].err;
         run_frame(int'(vecs[v].len), 1'b0);
      end

      // Last write byte coinciding with cs_n rise, then cs_n rise mid-byte.
      fbuf[0] = 8'h01;
      fbuf[1] = 8'h77;
      model_frame(2);
      run_frame(2, 1'b1);
      chk("coincide_reg1", 32'(regs_flat[15:8]), 32'h77);
      fbuf[0] = 8'h01;
      model_frame(1);
      run_frame(1, 1'b0);
      chk("midbyte_reg1", 32'(regs_flat[15:8]), 32'h77);

      // Reset in the middle of a write frame aborts it.
      cs_n = 1'b0;
      tick();
      send(8'h40);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      send(8'hAB);
      send(8'hCD);
      chk("midreset_regs", regs_flat, 32'h0);
      chk("midreset_tx", 32'(tx_byte), 32'h0);
      cs_n = 1'b1;
      tick();
      chk("midreset_frame_done", 32'(frame_done), 32'h0);
      tick();
      for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      m_err = 1'b0;
      $display("mid-frame reset sequence regs=%08h", regs_flat);

      // Random frames against the model
      for (int f = 0; f < 80; f++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: a = 4'($urandom_range(0, NUM_REGS - 1));
            6, 7:             a = 4'hF;
            default:          a = 4'($urandom_range(NUM_REGS, 14));
         endcase
         c[7]   = 1'($urandom_range(0, 1));
         c[6]   = 1'($urandom_range(0, 1));
         c[5:4] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         c[3:0] = a;
         len    = $urandom_range(1, 5);
         co     = ($urandom_range(0, 3) == 0);
         fbuf[0] = c;
         for (int k = 1; k < len; k++) fbuf[k] = 8'($urandom);
         model_frame(len);
         run_frame(len, co);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
- Command/register controller between the SPI slave byte interface and the display/control datapath.
- Parses each chip-select frame into a command byte plus data bytes, and performs register writes or reads, with optional auto-increment.
- Drives the 16-bit display value and supplies the MISO response byte to the slave.
- Sits in the top level between spi_slave and seven_seg.

Parameters:
- NUM_REGS, 4, number of read/write byte registers (2..15); reg0/reg1 form the display value.
- ID_VALUE, 8'hA5, read-only identification byte at address 4'hF.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cs_n  input  1  chip select, already synchronised to clk, low = frame active
- rx_valid  input  1  one-cycle pulse: rx_byte holds a completed byte
- rx_byte  input  8  received MOSI byte
- tx_byte  output  8  byte the slave shifts out on MISO for the next byte slot
- regs_flat  output  NUM_REGS*8  all registers; reg i at [8i+7:8i]
- disp_value  output  16  {reg1, reg0} to the display driver
- err  output  1  sticky protocol-error flag
- frame_done  output  1  one-cycle pulse when a frame ends (cs_n rises)

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE; all registers, tx_byte, err and frame_done = 0; addr=0; cmd flags=0.
  - Reset mid-frame aborts the frame. After reset, CMD is entered only on an observed cs_n falling edge, so a frame already in progress is ignored until cs_n rises and falls again.
- Command byte: bit7 = R(1)/W(0); bit6 = AI (auto-increment); bits5:4 reserved, must be 0; bits3:0 = addr.
- Valid command: reserved bits = 0 and (addr < NUM_REGS or addr = 4'hF).
- States: IDLE, CMD, WRITE, READ, DISCARD.
- IDLE:
  - cs_n falling edge -> CMD.
  - Same cycle: tx_byte <= {7'b0, err}, the status byte seen during the command slot.
- CMD, on rx_valid:
  - Invalid command -> DISCARD; err <= 1; tx_byte <= 8'h00.
  - Valid write -> WRITE; latch addr and AI.
  - Valid read -> READ; latch addr and AI; tx_byte <= value(addr) next cycle.
- WRITE, each rx_valid:
  - addr < NUM_REGS: reg[addr] <= rx_byte, visible on regs_flat/disp_value the following cycle.
  - addr = 4'hF: data discarded; err <= 0 (write-to-ID clears the error).
  - Then addr advances per the AI rule.
- READ, each rx_valid:
  - rx_byte is ignored.
  - addr advances per the AI rule; tx_byte <= value(new addr) the next cycle.
  - Thus the first data slot returns value(cmd addr) and later slots return successive registers.
- value(a): reg[a] for a < NUM_REGS; ID_VALUE for a = 4'hF.
- AI rule:
  - AI=0: addr fixed.
  - AI=1 and addr = NUM_REGS-1: wrap to 0.
  - AI=1 otherwise (addr < NUM_REGS-1): addr+1.
  - addr = 4'hF never increments.
- DISCARD: all further bytes in the frame are ignored; tx_byte stays 8'h00.
- Frame end: cs_n high in any non-IDLE state -> IDLE next cycle; frame_done pulses for exactly 1 cycle. A partial byte has no effect.
- Simultaneous rx_valid and cs_n rise in the same cycle: the byte is processed first (write commits), then the frame ends and frame_done pulses.
- rx_valid while in IDLE: ignored.
- Latency: rx_valid at cycle N -> register and tx_byte updates visible at N+1.
- Timing requirement: the slave samples tx_byte at least 2 clk cycles after rx_valid.
- err is set only by an invalid command and cleared only by reset or a write to 4'hF. A set and a clear in the same frame are applied in byte order.

Decomposition:
- Package spi_ctrl_pkg:
  - state_t enum.
  - Command bit-position constants: CMD_RW_BIT=7, CMD_AI_BIT=6, CMD_RSV_MSB=5, CMD_RSV_LSB=4.
  - ID_ADDR=4'hF.
  - STATUS byte layout.
- Sub-module spi_reg_file:
  - NUM_REGS x 8 storage with synchronous write port.
  - Combinational read of value(a), including the ID mux.
  - Flat output.
- spi_reg_ctrl holds the FSM, address counter, err flag and tx_byte register.

Test Plan:
- Reset with cs_n low, then a byte 8'h00 sent without a new falling edge -> no state change, regs_flat = 0, frame_done = 0 until cs_n rises.
- Frame [8'h40, 8'h34, 8'h12] (write, AI, addr 0) -> reg0 = 8'h34, reg1 = 8'h12, disp_value = 16'h1234 one cycle after the last rx_valid; frame_done one pulse.
- With regs 0..3 = 11,22,33,44: frame [8'hC2, x, x, x] (read, AI, addr 2) -> tx_byte sequence 8'h33, 8'h44, 8'h11 (wrap).
- Frame [8'h35, 8'hFF] (reserved bits set) -> err = 1, no register changes, tx_byte = 8'h00. Next frame's command slot -> tx_byte = 8'h01. Then frame [8'h0F, 8'h00] -> err = 0.
- Read ID [8'h8F, x, x] with AI=0 -> tx_byte 8'hA5 for both data slots. Repeat with AI=1 (8'hCF) -> still 8'hA5, no increment.
- rx_valid with byte 8'h77 coinciding with cs_n rise in a write frame to addr 1 -> reg1 = 8'h77, state IDLE, frame_done pulse. cs_n rise mid-byte (no rx_valid) -> no write.
